// File: rtl/zsram_pkg.sv
// Shared types and default sizing for the ZSRAM read/write sequencers.
package zsram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SETTLE,
      CAPTURE,
      HOLD
   } zsram_rd_state_t;

   localparam int ZSRAM_WIDTH   = 8;
   localparam int ZSRAM_DEPTH   = 16;
   localparam int ZSRAM_SETTLE  = 2;
   localparam int ZSRAM_ADDR_W  = $clog2(ZSRAM_DEPTH);
   localparam int ZSRAM_BURST_W = 4;

endpackage

// File: rtl/zsram_settle_timer.sv
// Loadable down-counter; done is high while the count sits at 1, i.e. in the
// final cycle of the loaded interval.
module zsram_settle_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == CNT_W'(1));

endmodule

// File: rtl/zsram_read_sequencer.sv
// Read-side controller for a ZSRAM bank: strobes ReadEdge on the addressed row,
// waits for the cells to settle, captures the word and hands it over valid/ack.
module zsram_read_sequencer
   import zsram_pkg::*;
#(
   parameter int WIDTH   = ZSRAM_WIDTH,
   parameter int DEPTH   = ZSRAM_DEPTH,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int SETTLE  = ZSRAM_SETTLE,
   parameter int BURST_W = ZSRAM_BURST_W
) (
   input  logic               Crystal50Mhz1,
   input  logic               nReset,
   input  logic               ReadRequest,
   input  logic [ADDR_W-1:0]  ReadAddress,
   input  logic [BURST_W-1:0] BurstLength,
   output logic               ReadReady,
   output logic [WIDTH-1:0]   ReadData,
   output logic               ReadValid,
   output logic               ReadLast,
   input  logic               ReadAck,
   input  logic               WriteBusy,
   output logic [ADDR_W-1:0]  CellAddress,
   output logic               ReadEdge,
   input  logic [WIDTH-1:0]   CellData
);

   localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   zsram_rd_state_t    state;
   zsram_rd_state_t    next_state;
   logic [BURST_W-1:0] remaining;
   logic               cnt_load;
   logic               cnt_done;

   // The counter keeps the SETTLE state exactly SETTLE cycles long.
   zsram_settle_timer #(
      .CNT_W (CNT_W)
   ) u_settle_timer (
      .clk   (Crystal50Mhz1),
      .rst_n (nReset),
      .load  (cnt_load),
      .value (CNT_W'(SETTLE)),
      .done  (cnt_done)
   );

   always_ff @(posedge Crystal50Mhz1 or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ReadEdge is gated directly by WriteBusy so a strobe never overlaps a write.
   always_comb begin
      next_state = state;
      cnt_load   = 1'b0;
      ReadReady  = 1'b0;
      ReadEdge   = 1'b0;
      case (state)
         IDLE: begin
            ReadReady = 1'b1;
            if (ReadRequest) next_state = ARM;
         end
         ARM: begin
            ReadEdge = !WriteBusy;
            if (!WriteBusy) begin
               next_state = zsram_pkg::SETTLE;
               cnt_load   = 1'b1;
            end
         end
         zsram_pkg::SETTLE: begin
            if (cnt_done) next_state = CAPTURE;
         end
         CAPTURE: begin
            next_state = HOLD;
         end
         HOLD: begin
            if (ReadAck) next_state = (remaining == '0) ? IDLE : ARM;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge Crystal50Mhz1 or negedge nReset) begin
      if (!nReset) begin
         CellAddress <= '0;
         remaining   <= '0;
         ReadData    <= '0;
         ReadValid   <= 1'b0;
         ReadLast    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ReadRequest) begin
                  CellAddress <= ReadAddress;
                  remaining   <= (BurstLength == '0) ? '0 : BurstLength - 1'b1;
               end
            end
            CAPTURE: begin
               ReadData  <= CellData;
               ReadValid <= 1'b1;
               ReadLast  <= (remaining == '0);
            end
            HOLD: begin
               if (ReadAck) begin
                  ReadValid <= 1'b0;
                  ReadLast  <= 1'b0;
                  if (remaining != '0) begin
                     CellAddress <= ADDR_W'((int'(CellAddress) + 1) % DEPTH);
                     remaining   <= remaining - 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zsram_read_sequencer.sv
// Directed bench for zsram_read_sequencer: single read, wrapping burst, write
// contention, backpressure, reset mid-burst and zero-length burst.
module tb_zsram_read_sequencer;

   logic       Crystal50Mhz1 = 1'b0;
   logic       nReset;
   logic       ReadRequest;
   logic [3:0] ReadAddress;
   logic [3:0] BurstLength;
   logic       ReadReady;
   logic [7:0] ReadData;
   logic       ReadValid;
   logic       ReadLast;
   logic       ReadAck;
   logic       WriteBusy;
   logic [3:0] CellAddress;
   logic       ReadEdge;
   logic [7:0] CellData;

   int checks     = 0;
   int failures   = 0;
   int edge_count = 0;
   int overlap    = 0;

   zsram_read_sequencer dut (
      .Crystal50Mhz1 (Crystal50Mhz1),
      .nReset        (nReset),
      .ReadRequest   (ReadRequest),
      .ReadAddress   (ReadAddress),
      .BurstLength   (BurstLength),
      .ReadReady     (ReadReady),
      .ReadData      (ReadData),
      .ReadValid     (ReadValid),
      .ReadLast      (ReadLast),
      .ReadAck       (ReadAck),
      .WriteBusy     (WriteBusy),
      .CellAddress   (CellAddress),
      .ReadEdge      (ReadEdge),
      .CellData      (CellData)
   );

   always #5 Crystal50Mhz1 = ~Crystal50Mhz1;

   // Cell array model: row 3 holds A5, every other row holds {~addr, addr}.
   function automatic logic [7:0] cell_model(input logic [3:0] a);
      if (a == 4'd3) return 8'hA5;
      return {~a, a};
   endfunction

   assign CellData = cell_model(CellAddress);

   always @(negedge Crystal50Mhz1) begin
      if (ReadEdge) edge_count++;
      if (ReadEdge && WriteBusy) overlap++;
   end

   task automatic tick();
      @(posedge Crystal50Mhz1);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int max_cycles, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!ReadValid && cyc < max_cycles);
      check("valid_timeout", 32'(ReadValid), 32'd1);
   endtask

   initial begin
      logic [7:0] burst_exp [4];
      int cyc;
      int e0;
      int bad;

      burst_exp[0] = 8'h1E;
      burst_exp[1] = 8'h0F;
      burst_exp[2] = 8'hF0;
      burst_exp[3] = 8'hE1;

      nReset      = 1'b0;
      ReadRequest = 1'b0;
      ReadAddress = '0;
      BurstLength = '0;
      ReadAck     = 1'b0;
      WriteBusy   = 1'b0;
      #3;
      check("reset_ready", 32'(ReadReady), 32'd1);
      check("reset_outputs", {ReadEdge, ReadValid, ReadLast, ReadData, CellAddress},
            32'd0);
      repeat (2) @(posedge Crystal50Mhz1);
      #1 nReset = 1'b1;
      tick();

      // Single read of row 3.
      ReadRequest = 1'b1;
      ReadAddress = 4'd3;
      BurstLength = 4'd1;
      tick();
      ReadRequest = 1'b0;
      check("single_edge_high", 32'(ReadEdge), 32'd1);
      check("single_cell_addr", 32'(CellAddress), 32'd3);
      check("single_busy", 32'(ReadReady), 32'd0);
      tick();
      check("single_edge_once", 32'(ReadEdge), 32'd0);
      tick();
      tick();
      check("single_not_early", 32'(ReadValid), 32'd0);
      tick();
      check("single_word", {ReadValid, ReadLast, ReadData}, {22'd0, 1'b1, 1'b1, 8'hA5});
      ReadAck = 1'b1;
      tick();
      ReadAck = 1'b0;
      check("single_done", {ReadValid, ReadReady, ReadData}, {22'd0, 1'b0, 1'b1, 8'hA5});

      // Burst of four from row 14 wraps to rows 0 and 1.
      ReadRequest = 1'b1;
      ReadAddress = 4'd14;
      BurstLength = 4'd4;
      tick();
      ReadRequest = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_valid(20, cyc);
         check("burst_latency", 32'(cyc), 32'd4);
         check("burst_data", 32'(ReadData), 32'(burst_exp[i]));
         check("burst_last", 32'(ReadLast), (i == 3) ? 32'd1 : 32'd0);
         ReadAck = 1'b1;
         tick();
         ReadAck = 1'b0;
      end
      check("burst_idle", 32'(ReadReady), 32'd1);

      // Write contention for five cycles after acceptance.
      WriteBusy   = 1'b1;
      ReadRequest = 1'b1;
      ReadAddress = 4'd9;
      BurstLength = 4'd1;
      tick();
      ReadRequest = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("contention_edge_low", 32'(ReadEdge), 32'd0);
         tick();
      end
      WriteBusy = 1'b0;
      #1;
      check("contention_edge_release", 32'(ReadEdge), 32'd1);
      wait_valid(20, cyc);
      check("contention_latency", 32'(cyc), 32'd4);
      check("contention_data", {ReadLast, ReadData}, {23'd0, 1'b1, 8'h69});

      // Backpressure: word held for ten cycles without ack.
      e0 = edge_count;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("bp_hold", {ReadValid, ReadData}, {23'd0, 1'b1, 8'h69});
      end
      check("bp_no_edge", 32'(edge_count), 32'(e0));
      ReadAck = 1'b1;
      tick();
      check("bp_ack", {ReadValid, ReadReady}, 32'd1);
      repeat (3) tick();
      ReadAck = 1'b0;
      check("idle_ack_ignored", {ReadValid, ReadReady, ReadData}, {22'd0, 1'b0, 1'b1, 8'h69});
      check("idle_ack_no_edge", 32'(edge_count), 32'(e0));

      // Reset while word 2 of 4 is settling.
      ReadRequest = 1'b1;
      ReadAddress = 4'd0;
      BurstLength = 4'd4;
      tick();
      ReadRequest = 1'b0;
      wait_valid(20, cyc);
      check("rst_first_word", 32'(ReadData), 32'hF0);
      ReadAck = 1'b1;
      tick();
      ReadAck = 1'b0;
      tick();
      check("rst_in_settle", {ReadEdge, ReadValid, CellAddress}, 32'd1);
      nReset = 1'b0;
      #1;
      check("rst_immediate", {ReadEdge, ReadValid, ReadReady, ReadData, CellAddress},
            {19'd0, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0});
      repeat (2) tick();
      nReset = 1'b1;
      e0  = edge_count;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (ReadValid || !ReadReady) bad++;
      end
      check("rst_no_stale", 32'(bad), 32'd0);
      check("rst_no_edge", 32'(edge_count), 32'(e0));

      // Zero burst length behaves as a single read.
      ReadRequest = 1'b1;
      ReadAddress = 4'd3;
      BurstLength = 4'd0;
      tick();
      ReadRequest = 1'b0;
      wait_valid(20, cyc);
      check("bl0_latency", 32'(cyc), 32'd4);
      check("bl0_word", {ReadLast, ReadData}, {23'd0, 1'b1, 8'hA5});
      ReadAck = 1'b1;
      tick();
      ReadAck = 1'b0;
      check("bl0_done", {ReadValid, ReadReady}, 32'd1);
      e0 = edge_count;
      repeat (8) tick();
      check("bl0_single_word", {ReadValid, 24'(edge_count - e0)}, 32'd0);

      check("no_edge_during_write", 32'(overlap), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
